// File: rtl/spi_slave.sv
// SPI slave: CPOL/CPHA modes, 1..8 byte frames, shadowed response word.
// Build option: define SPI_SLAVE_SYNC2_EN for two-flop input synchronizers (default: one stage).
module spi_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [2:0]  byte_num,
    input  logic [63:0] tx_data,
    input  logic        tx_load,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
    state_t state, state_nxt;

    logic        sck_p0, cs_p0, mosi_p0, vld_p0;
    logic        sck_s, cs_s, mosi_s, vld_s;
    logic        sck_d, cs_d;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;
    logic        lead_edge, trail_edge, sample_edge, shift_edge;
    logic        cpol, cpha, armed, tx_live;
    logic        start, fin, abort, fin_p0;
    logic [6:0]  n_bits, frame_n, cnt;
    logic [63:0] shadow, tx_shift, rx_shift;

    function automatic logic [63:0] align_msb(input logic [63:0] word, input logic [6:0] nb);
        align_msb = word << (7'd64 - nb);
    endfunction

    // Input capture stage; vld marks that the stage holds a real bus sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_p0  <= 1'b0;
            cs_p0   <= 1'b1;
            mosi_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            sck_p0  <= sck;
            cs_p0   <= cs;
            mosi_p0 <= mosi;
            vld_p0  <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_SYNC2_EN
    logic sck_p1, cs_p1, mosi_p1, vld_p1;

    // Second synchronizer stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_p1  <= 1'b0;
            cs_p1   <= 1'b1;
            mosi_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sck_p1  <= sck_p0;
            cs_p1   <= cs_p0;
            mosi_p1 <= mosi_p0;
            vld_p1  <= vld_p0;
        end
    end

    assign sck_s  = sck_p1;
    assign cs_s   = cs_p1;
    assign mosi_s = mosi_p1;
    assign vld_s  = vld_p1;
`else
    assign sck_s  = sck_p0;
    assign cs_s   = cs_p0;
    assign mosi_s = mosi_p0;
    assign vld_s  = vld_p0;
`endif

    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign cs_rise     = cs_s & ~cs_d;
    assign cs_fall     = ~cs_s & cs_d;
    assign lead_edge   = cpol ? sck_fall : sck_rise;
    assign trail_edge  = cpol ? sck_rise : sck_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign n_bits      = (byte_num == 3'd0) ? 7'd64 : {1'b0, byte_num, 3'b000};

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fin       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_nxt = XFER;
                    start     = 1'b1;
                end
            end
            XFER: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (sample_edge && (cnt + 7'd1 == frame_n)) begin
                    state_nxt = HOLD;
                    fin       = 1'b1;
                end
            end
            HOLD: begin
                if (cs_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame control and shift registers; edge detection delays the synchronized bus by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
            cpol      <= 1'b0;
            cpha      <= 1'b0;
            frame_n   <= 7'd64;
            cnt       <= 7'd0;
            tx_live   <= 1'b0;
            tx_shift  <= 64'd0;
            rx_shift  <= 64'd0;
            shadow    <= 64'd0;
            fin_p0    <= 1'b0;
            rx_data   <= 64'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            // A frame may only start after a genuine high level on cs has been seen since reset.
            armed     <= armed | (vld_s & cs_s);
            fin_p0    <= fin;
            rx_valid  <= fin_p0;
            frame_err <= abort;
            if (fin_p0) rx_data <= rx_shift;
            if (tx_load) shadow <= tx_data;
            if (start) begin
                cpol     <= mode[1];
                cpha     <= mode[0];
                frame_n  <= n_bits;
                cnt      <= 7'd0;
                rx_shift <= 64'd0;
                tx_shift <= align_msb(tx_load ? tx_data : shadow, n_bits);
                tx_live  <= ~mode[0];
            end else if (state == XFER) begin
                if (shift_edge) begin
                    if (tx_live) tx_shift <= {tx_shift[62:0], 1'b0};
                    tx_live <= 1'b1;
                end
                if (sample_edge && (cnt < frame_n)) begin
                    rx_shift <= {rx_shift[62:0], mosi_s};
                    cnt      <= cnt + 7'd1;
                end
            end
        end
    end

    assign miso    = (state == XFER) && tx_live && tx_shift[63];
    assign miso_oe = (state != IDLE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench acts as SPI master and checks both directions.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [2:0]  byte_num;
    logic [63:0] tx_data;
    logic        tx_load;
    logic        sck, cs, mosi;
    logic        miso, miso_oe, rx_valid, busy, frame_err;
    logic [63:0] rx_data;

    int checks = 0;
    int failures = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    spi_slave dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .byte_num  (byte_num),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rv_cnt++;
        if (frame_err) fe_cnt++;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_tx(input logic [63:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic sck_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Master side of one frame: nclk sck cycles, sends mword[nclk-1:0] MSB first, returns what miso carried.
    task automatic spi_frame(input string tag, input logic [1:0] md, input logic [2:0] bn, input int nclk,
                             input logic [63:0] mword, input logic full, output logic [63:0] sword);
        logic        cpol, cpha;
        logic [63:0] m;
        cpol  = md[1];
        cpha  = md[0];
        sword = 64'd0;
        m     = mword << (64 - nclk);
        @(negedge clk);
        mode     = md;
        byte_num = bn;
        sck      = cpol;
        mosi     = 1'b0;
        repeat (8) @(negedge clk);
        cs = 1'b0;
        if (!cpha) begin
            mosi = m[63];
            m    = m << 1;
        end
        repeat (HALF + 3) @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_oe"}, 64'(miso_oe), 64'd1);
        for (int i = 0; i < nclk; i++) begin
            if (!cpha) begin
                sword = {sword[62:0], miso};
                sck   = ~cpol;
                repeat (HALF) @(negedge clk);
                sck  = cpol;
                mosi = m[63];
                m    = m << 1;
                repeat (HALF) @(negedge clk);
            end else begin
                sck  = ~cpol;
                mosi = m[63];
                m    = m << 1;
                repeat (HALF) @(negedge clk);
                sword = {sword[62:0], miso};
                sck   = cpol;
                repeat (HALF) @(negedge clk);
            end
        end
        if (full) begin
            check({tag, "_hold_miso"}, 64'(miso), 64'd0);
            check({tag, "_hold_busy"}, 64'(busy), 64'd1);
        end
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
        check({tag, "_idle_oe"}, 64'(miso_oe), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        int          rv0, fe0;

        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        mode = 2'd0; byte_num = 3'd0; tx_data = 64'd0; tx_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_oe", 64'(miso_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rxv", 64'(rx_valid), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        check("rst_rxdata", rx_data, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0, one byte.
        load_tx(64'hA5);
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_frame("m0", 2'd0, 3'd1, 8, 64'h3C, 1'b1, got);
        check("m0_miso_bits", got, 64'hA5);
        check("m0_rx", rx_data, 64'h3C);
        check("m0_rxv_cnt", 64'(rv_cnt - rv0), 64'd1);
        check("m0_ferr_cnt", 64'(fe_cnt - fe0), 64'd0);

        // Mode 3, two bytes.
        load_tx(64'h1234);
        rv0 = rv_cnt;
        spi_frame("m3", 2'd3, 3'd2, 16, 64'hBEEF, 1'b1, got);
        check("m3_miso", got, 64'h1234);
        check("m3_rx", rx_data, 64'hBEEF);
        check("m3_rxv_cnt", 64'(rv_cnt - rv0), 64'd1);

        // Eight-byte frames in modes 1 and 2.
        load_tx(64'h0123456789ABCDEF);
        rv0 = rv_cnt;
        spi_frame("m1", 2'd1, 3'd0, 64, 64'hFEDCBA9876543210, 1'b1, got);
        check("m1_miso", got, 64'h0123456789ABCDEF);
        check("m1_rx", rx_data, 64'hFEDCBA9876543210);
        check("m1_rxv_cnt", 64'(rv_cnt - rv0), 64'd1);
        spi_frame("m2", 2'd2, 3'd0, 64, 64'hFEDCBA9876543210, 1'b1, got);
        check("m2_miso", got, 64'h0123456789ABCDEF);
        check("m2_rx", rx_data, 64'hFEDCBA9876543210);

        // Short frame: cs released after 5 of 8 bits.
        load_tx(64'hF0);
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_frame("short", 2'd0, 3'd1, 5, 64'h15, 1'b0, got);
        check("short_miso", got, 64'h1E);
        check("short_ferr_cnt", 64'(fe_cnt - fe0), 64'd1);
        check("short_rxv_cnt", 64'(rv_cnt - rv0), 64'd0);
        check("short_rx_kept", rx_data, 64'hFEDCBA9876543210);
        load_tx(64'h5A);
        spi_frame("after_short", 2'd0, 3'd1, 8, 64'h81, 1'b1, got);
        check("after_short_miso", got, 64'h5A);
        check("after_short_rx", rx_data, 64'h81);
        check("after_short_rxv_cnt", 64'(rv_cnt - rv0), 64'd1);

        // Reset in the middle of a frame with cs held low.
        load_tx(64'h77);
        rv0 = rv_cnt; fe0 = fe_cnt;
        mode = 2'd0; byte_num = 3'd1; sck = 1'b0;
        repeat (8) @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        sck_cycles(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sck_cycles(9);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_oe", 64'(miso_oe), 64'd0);
        check("rst_mid_rxv_cnt", 64'(rv_cnt - rv0), 64'd0);
        check("rst_mid_ferr_cnt", 64'(fe_cnt - fe0), 64'd0);
        check("rst_mid_rx", rx_data, 64'd0);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_busy_cs_high", 64'(busy), 64'd0);
        load_tx(64'hC3);
        spi_frame("post_rst", 2'd0, 3'd1, 8, 64'h96, 1'b1, got);
        check("post_rst_miso", got, 64'hC3);
        check("post_rst_rx", rx_data, 64'h96);
        check("post_rst_rxv_cnt", 64'(rv_cnt - rv0), 64'd1);

        // tx_load during a frame only affects the following frame.
        load_tx(64'hAA);
        fork
            spi_frame("shadow_a", 2'd0, 3'd1, 8, 64'h11, 1'b1, got);
            begin
                repeat (40) @(negedge clk);
                load_tx(64'h55);
            end
        join
        check("shadow_a_miso", got, 64'hAA);
        check("shadow_a_rx", rx_data, 64'h11);
        spi_frame("shadow_b", 2'd0, 3'd1, 8, 64'h22, 1'b1, got);
        check("shadow_b_miso", got, 64'h55);
        check("shadow_b_rx", rx_data, 64'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
